// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: registered decode-and-issue stage between fetch and execute.
// It splits each accepted instruction word into opcode, register, immediate,
// lane-mask and memory fields, and hands them to execute over valid/ready.
// It also holds fetch while a memory op occupies the stage, until a branch
// resolves, and while the core is halted.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   instr, in_valid      instruction word from fetch and its valid
//   in_ready             stage accepts an instruction this cycle
//   exe_ready            execute accepts the decoded op
//   dec_valid            decoded op valid
//   opcode, addr_rega, addr_regb, mem_addr, jdata, data_imm
//                        fields of the accepted word
//   we_rf                per-lane register write enable
//   mem_we, mem_alu      store op, load op
//   exe_valid, opcode_exe, zero
//                        completion report from execute (branch resolution)
//   jump                 one-cycle branch-taken pulse to fetch
//   resume, halted       leave HALTED, core halted
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_RUN      | normal issue; accepts an instruction when downstream allows
// S_MEM_WAIT | load/store occupying the stage, cnt_q counts down to 1
// S_BR_WAIT  | branch issued, waiting for execute to resolve it
// S_HALTED   | HALT issued, waiting for resume
module vec_issue_ctrl #(
  parameter int WIDTH_INSTR  = 32,
  parameter int WIDTH_OPCODE = 4,
  parameter int WA_RF        = 6,
  parameter int WIDTH_VECTOR = 8,
  parameter int WIDTH_JDATA  = 24,
  parameter int MEM_LAT      = 3,
  localparam int WA_MEM      = WIDTH_INSTR - WIDTH_OPCODE - WA_RF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH_INSTR-1:0]  instr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    exe_ready,
  output logic                    dec_valid,
  output logic [WIDTH_OPCODE-1:0] opcode,
  output logic [WA_RF-1:0]        addr_rega,
  output logic [WA_RF-1:0]        addr_regb,
  output logic [WA_MEM-1:0]       mem_addr,
  output logic [WIDTH_JDATA-1:0]  jdata,
  output logic [WIDTH_VECTOR-1:0] data_imm,
  output logic [WIDTH_VECTOR-1:0] we_rf,
  output logic                    mem_we,
  output logic                    mem_alu,
  input  logic                    exe_valid,
  input  logic [WIDTH_OPCODE-1:0] opcode_exe,
  input  logic                    zero,
  output logic                    jump,
  input  logic                    resume,
  output logic                    halted
);

  localparam int CW  = $clog2(MEM_LAT + 1);
  // Keep the counter at least one bit wide so MEM_LAT=0 still elaborates.
  localparam int CWS = (CW < 1) ? 1 : CW;

  localparam logic [WIDTH_OPCODE-1:0] OP_ALU   = WIDTH_OPCODE'(4'b0110);
  localparam logic [WIDTH_OPCODE-1:0] OP_JZ    = WIDTH_OPCODE'(4'b1001);
  localparam logic [WIDTH_OPCODE-1:0] OP_JMP   = WIDTH_OPCODE'(4'b1010);
  localparam logic [WIDTH_OPCODE-1:0] OP_STORE = WIDTH_OPCODE'(4'b1011);
  localparam logic [WIDTH_OPCODE-1:0] OP_LOAD  = WIDTH_OPCODE'(4'b1100);
  localparam logic [WIDTH_OPCODE-1:0] OP_HALT  = WIDTH_OPCODE'(4'b1101);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_BR_WAIT  = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CWS-1:0]          cnt_q, cnt_d;
  logic                    dec_valid_q, dec_valid_d;
  logic [WIDTH_INSTR-1:0]  instr_q, instr_d;
  logic [WIDTH_VECTOR-1:0] we_rf_q, we_rf_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_alu_q, mem_alu_d;
  logic                    jump_q, jump_d;
  logic                    halted_q, halted_d;

  logic                    acc;
  logic [WIDTH_OPCODE-1:0] op_in;

  assign op_in    = instr[WIDTH_INSTR-1 -: WIDTH_OPCODE];
  assign in_ready = (state_q == S_RUN) & ~jump_q & (~dec_valid_q | exe_ready);
  assign acc      = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    jump_d      = 1'b0;
    halted_d    = halted_q;
    dec_valid_d = dec_valid_q;
    instr_d     = instr_q;
    we_rf_d     = we_rf_q;
    mem_we_d    = mem_we_q;
    mem_alu_d   = mem_alu_q;

    unique case (state_q)
      S_RUN: begin
        if (acc) begin
          if (((op_in == OP_STORE) || (op_in == OP_LOAD)) && (MEM_LAT > 0)) begin
            state_d = S_MEM_WAIT;
            cnt_d   = CWS'(MEM_LAT);
          end else if ((op_in == OP_JZ) || (op_in == OP_JMP)) begin
            state_d = S_BR_WAIT;
          end else if (op_in == OP_HALT) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end
        end
      end
      S_MEM_WAIT: begin
        cnt_d = cnt_q - CWS'(1);
        if (cnt_q == CWS'(1)) begin
          state_d = S_RUN;
        end
      end
      S_BR_WAIT: begin
        // Only a branch completing in execute resolves the wait.
        if (exe_valid && ((opcode_exe == OP_JZ) || (opcode_exe == OP_JMP))) begin
          state_d = S_RUN;
          jump_d  = (opcode_exe == OP_JMP) | zero;
        end
      end
      S_HALTED: begin
        if (resume) begin
          state_d  = S_RUN;
          halted_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase

    // Decoded outputs change only on accept; otherwise they hold, and
    // dec_valid drops once execute has taken the op.
    if (acc) begin
      dec_valid_d = 1'b1;
      instr_d     = instr;
      mem_we_d    = (op_in == OP_STORE);
      mem_alu_d   = (op_in == OP_LOAD);
      unique case (op_in)
        OP_ALU, OP_LOAD:                   we_rf_d = '1;
        OP_JZ, OP_JMP, OP_STORE, OP_HALT:  we_rf_d = '0;
        default:                           we_rf_d = instr[WIDTH_VECTOR-1:0];
      endcase
    end else if (exe_ready) begin
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      dec_valid_q <= 1'b0;
      instr_q     <= '0;
      we_rf_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_alu_q   <= 1'b0;
      jump_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_valid_q <= dec_valid_d;
      instr_q     <= instr_d;
      we_rf_q     <= we_rf_d;
      mem_we_q    <= mem_we_d;
      mem_alu_q   <= mem_alu_d;
      jump_q      <= jump_d;
      halted_q    <= halted_d;
    end
  end

  assign dec_valid = dec_valid_q;
  assign opcode    = instr_q[WIDTH_INSTR-1 -: WIDTH_OPCODE];
  assign addr_rega = instr_q[WIDTH_INSTR-WIDTH_OPCODE-1 -: WA_RF];
  assign addr_regb = instr_q[WIDTH_INSTR-WIDTH_OPCODE-WA_RF-1 -: WA_RF];
  assign mem_addr  = instr_q[WA_MEM-1:0];
  assign jdata     = instr_q[WIDTH_JDATA-1:0];
  assign data_imm  = instr_q[WIDTH_VECTOR-1:0];
  assign we_rf     = we_rf_q;
  assign mem_we    = mem_we_q;
  assign mem_alu   = mem_alu_q;
  assign jump      = jump_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
module tb_vec_issue_ctrl;

  localparam int MEM_LAT = 3;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        exe_ready;
  logic        dec_valid;
  logic [3:0]  opcode;
  logic [5:0]  addr_rega;
  logic [5:0]  addr_regb;
  logic [21:0] mem_addr;
  logic [23:0] jdata;
  logic [7:0]  data_imm;
  logic [7:0]  we_rf;
  logic        mem_we;
  logic        mem_alu;
  logic        exe_valid;
  logic [3:0]  opcode_exe;
  logic        zero;
  logic        jump;
  logic        resume;
  logic        halted;

  vec_issue_ctrl #(
    .WIDTH_INSTR(32), .WIDTH_OPCODE(4), .WA_RF(6), .WIDTH_VECTOR(8),
    .WIDTH_JDATA(24), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready), .exe_ready(exe_ready), .dec_valid(dec_valid),
    .opcode(opcode), .addr_rega(addr_rega), .addr_regb(addr_regb),
    .mem_addr(mem_addr), .jdata(jdata), .data_imm(data_imm), .we_rf(we_rf),
    .mem_we(mem_we), .mem_alu(mem_alu), .exe_valid(exe_valid),
    .opcode_exe(opcode_exe), .zero(zero), .jump(jump), .resume(resume),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: what the stage is doing, in plain terms.
  int          m_mem_left;  // remaining cycles the stage is busy with a memory op
  bit          m_br;        // branch issued, not yet resolved
  bit          m_halt;
  bit          m_jump;
  bit          m_dv;
  logic [31:0] m_instr;     // last accepted word
  logic        last_rdy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [82:0] act_bundle();
    return {dec_valid, opcode, addr_rega, addr_regb, mem_addr, jdata, data_imm,
            we_rf, mem_we, mem_alu, jump, halted};
  endfunction

  function automatic logic [82:0] exp_bundle();
    int unsigned w, op;
    logic [7:0]  we;
    w  = m_instr;
    op = w >> 28;
    if (op == 6 || op == 12)                          we = 8'hFF;
    else if (op == 9 || op == 10 || op == 11 || op == 13) we = 8'h00;
    else                                              we = 8'(w % 256);
    return {m_dv, 4'(op), 6'((w >> 22) % 64), 6'((w >> 16) % 64),
            22'(w % (1 << 22)), 24'(w % (1 << 24)), 8'(w % 256), we,
            (op == 11), (op == 12), m_jump, m_halt};
  endfunction

  function automatic bit exp_ready();
    return (m_mem_left == 0) && !m_br && !m_halt && !m_jump && (!m_dv || exe_ready);
  endfunction

  task automatic model_clear();
    m_mem_left = 0; m_br = 0; m_halt = 0; m_jump = 0; m_dv = 0; m_instr = '0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic tick();
    bit acc, jn;
    int unsigned op;
    #1;
    last_rdy = in_ready;
    chk("in_ready", 128'(in_ready), 128'(exp_ready()));
    acc = in_valid && exp_ready();
    jn  = 0;
    if (m_mem_left > 0) begin
      m_mem_left--;
    end else if (m_br) begin
      if (exe_valid && (opcode_exe == 9 || opcode_exe == 10)) begin
        m_br = 0;
        jn   = (opcode_exe == 10) || zero;
      end
    end else if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (acc) begin
      op = instr >> 28;
      if ((op == 11 || op == 12) && MEM_LAT > 0) m_mem_left = MEM_LAT;
      else if (op == 9 || op == 10)               m_br = 1;
      else if (op == 13)                          m_halt = 1;
    end
    if (acc) begin
      m_dv = 1; m_instr = instr;
    end else if (exe_ready) begin
      m_dv = 0;
    end
    m_jump = jn;
    @(posedge clk);
    #1;
    chk("outputs", 128'(act_bundle()), 128'(exp_bundle()));
  endtask

  task automatic idle_inputs();
    in_valid = 0; exe_valid = 0; opcode_exe = '0; zero = 0; resume = 0; exe_ready = 1;
  endtask

  initial begin
    rst_n = 0; instr = '0;
    idle_inputs();
    model_clear();
    #1;
    chk("reset_outputs", 128'(act_bundle()), 128'(0));
    #11 rst_n = 1;
    @(posedge clk); #1;

    // ALU-all
    in_valid = 1; instr = 32'h60C4_00A5;
    tick();
    in_valid = 0;
    chk("alu_valid", 128'(dec_valid), 128'(1));
    chk("alu_fields", 128'({opcode, addr_rega, addr_regb, data_imm, we_rf, mem_we, mem_alu}),
        128'({4'h6, 6'd3, 6'd4, 8'hA5, 8'hFF, 1'b0, 1'b0}));
    tick();

    // Load with MEM_LAT=3
    in_valid = 1; instr = 32'hC012_3456;
    tick();
    in_valid = 0;
    chk("load_fields", 128'({mem_alu, we_rf, mem_addr}), 128'({1'b1, 8'hFF, 22'h123456}));
    for (int i = 0; i < MEM_LAT; i++) begin
      tick();
      chk("load_busy", 128'(last_rdy), 128'(0));
    end
    tick();
    chk("load_free", 128'(last_rdy), 128'(1));

    // JZ not taken, then taken
    for (int z = 0; z < 2; z++) begin
      in_valid = 1; instr = 32'h9000_0010;
      tick();
      in_valid = 0;
      tick();
      chk("br_wait_rdy", 128'(last_rdy), 128'(0));
      exe_valid = 1; opcode_exe = 4'h9; zero = z[0];
      tick();
      chk("br_resolve_rdy", 128'(last_rdy), 128'(0));
      exe_valid = 0; zero = 0;
      chk("br_jump", 128'(jump), 128'(z));
      tick();
      chk("br_after_rdy", 128'(last_rdy), 128'(z == 0));
      chk("br_jump_clear", 128'(jump), 128'(0));
      if (z == 1) begin
        tick();
        chk("br_after_jump_rdy", 128'(last_rdy), 128'(1));
      end
    end

    // Backpressure
    in_valid = 1; instr = 32'h6123_4567;
    tick();
    exe_ready = 0; instr = 32'h1ABC_DEF0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_rdy", 128'(last_rdy), 128'(0));
      chk("bp_hold_op", 128'({dec_valid, opcode, jdata}), 128'({1'b1, 4'h6, 24'h234567}));
    end
    exe_ready = 1;
    tick();
    in_valid = 0;
    chk("bp_next_op", 128'({dec_valid, opcode, jdata}), 128'({1'b1, 4'h1, 24'hBCDEF0}));
    tick();
    chk("bp_drained", 128'(dec_valid), 128'(0));

    // HALT and resume
    in_valid = 1; instr = 32'hD000_0000;
    tick();
    in_valid = 0;
    chk("halt_set", 128'(halted), 128'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_rdy", 128'(last_rdy), 128'(0));
    end
    resume = 1;
    tick();
    resume = 0;
    chk("halt_clear", 128'(halted), 128'(0));
    tick();
    chk("resume_rdy", 128'(last_rdy), 128'(1));

    // Reset in the middle of a memory wait
    in_valid = 1; instr = 32'hB0AB_CDEF;
    tick();
    in_valid = 0;
    tick();
    rst_n = 0;
    #1;
    chk("midreset_outputs", 128'(act_bundle()), 128'(0));
    model_clear();
    #2 rst_n = 1;
    tick();
    chk("midreset_rdy", 128'(last_rdy), 128'(1));

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = $urandom;
      exe_ready = ($urandom_range(0, 3) != 0);
      exe_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       opcode_exe = 4'($urandom_range(0, 15));
        1:       opcode_exe = 4'h9;
        default: opcode_exe = 4'hA;
      endcase
      zero   = $urandom_range(0, 1);
      resume = ($urandom_range(0, 5) == 0);
      if (n % 500 == 499) begin
        rst_n = 0;
        #1;
        chk("rand_reset", 128'(act_bundle()), 128'(0));
        model_clear();
        #2 rst_n = 1;
      end
      tick();
    end

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vec_issue_ctrl.md
Name: vec_issue_ctrl

Overview:
Registered decode-and-issue stage for the vector core. It sits between instruction fetch and execute, and replaces the purely combinational decode. It splits each instruction word into opcode, register, immediate, lane-mask and memory fields, and hands them to execute over a valid/ready handshake. Unlike the old decoder, it sequences multi-cycle memory ops, holds fetch until each branch resolves, and supports HALT/resume.

Parameters:
WIDTH_INSTR, 32, instruction word width
WIDTH_OPCODE, 4, opcode field width (MSBs of the word)
WA_RF, 6, register address width (rega, then regb, below the opcode)
WIDTH_VECTOR, 8, lane count; width of the immediate and the write-enable mask
WIDTH_JDATA, 24, jump data field width (LSBs of the word)
MEM_LAT, 3, memory-op occupancy in cycles (0 = no wait state)
Derived: WA_MEM = WIDTH_INSTR-WIDTH_OPCODE-WA_RF; CW = $clog2(MEM_LAT+1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
instr  in  WIDTH_INSTR  instruction from fetch
in_valid  in  1  instr valid
in_ready  out  1  decoder accepts instr this cycle
exe_ready  in  1  execute accepts decoded op
dec_valid  out  1  decoded op valid
opcode  out  WIDTH_OPCODE  instr[WI-1:WI-WO]
addr_rega  out  WA_RF  next WA_RF bits below opcode
addr_regb  out  WA_RF  next WA_RF bits below rega
mem_addr  out  WA_MEM  instr[WA_MEM-1:0]
jdata  out  WIDTH_JDATA  instr[WIDTH_JDATA-1:0]
data_imm  out  WIDTH_VECTOR  instr[WIDTH_VECTOR-1:0]
we_rf  out  WIDTH_VECTOR  per-lane register write enable
mem_we  out  1  store op
mem_alu  out  1  load op (memory to register file)
exe_valid  in  1  execute reports a completing op
opcode_exe  in  WIDTH_OPCODE  opcode completing in execute
zero  in  1  execute zero flag
jump  out  1  one-cycle branch-taken pulse to fetch
resume  in  1  leave HALTED
halted  out  1  core halted

Behaviour:
- Reset (async, rst_n=0): state RUN, counter 0, and every output register 0 (dec_valid, fields, we_rf, mem_we, mem_alu, jump, halted).
- Opcodes: 0110 ALU-all; 1001 JZ; 1010 JMP; 1011 STORE; 1100 LOAD; 1101 HALT; all others are lane ops.
- Decode, registered on accept: all fields from instr.
  - mem_we = (op==1011); mem_alu = (op==1100).
  - we_rf = all-ones for 0110 and 1100; 0 for 1001, 1010, 1011 and 1101; otherwise instr[WIDTH_VECTOR-1:0].
- Accept: acc = in_valid & in_ready. Latency is 1 cycle: after the accept edge, dec_valid=1 with the decoded fields.
- in_ready = (state==RUN) & ~jump & (~dec_valid | exe_ready).
- Output hold: dec_valid & ~exe_ready keeps all decoded outputs stable. dec_valid clears on exe_ready unless a new acc occurs in the same cycle.
- FSM states: RUN, MEM_WAIT, BR_WAIT, HALTED.
- RUN:
  - acc of 1011/1100 with MEM_LAT>0: go to MEM_WAIT, cnt=MEM_LAT.
  - acc of 1001/1010: go to BR_WAIT.
  - acc of 1101: go to HALTED, halted=1.
  - otherwise stay in RUN.
- MEM_WAIT: cnt decrements each cycle; when cnt==1 go to RUN. in_ready is therefore low for exactly MEM_LAT cycles after the accept edge.
- BR_WAIT: wait for exe_valid & opcode_exe∈{1001,1010}, then go to RUN.
  - jump<=1 for one cycle if opcode_exe==1010, or if opcode_exe==1001 & zero; otherwise jump stays 0.
  - exe_valid with any other opcode is ignored.
  - in_ready stays 0 through the jump cycle.
- HALTED: in_ready=0. resume=1 clears halted and returns to RUN on the next edge. resume outside HALTED is ignored.
- The decoded op is always issued downstream, including HALT and branches.
- Reset mid-operation aborts any wait or halt: state RUN, cnt 0, pending op dropped.

Test Plan:
- ALU-all: instr=0x60C4_00A5 -> next cycle dec_valid=1, opcode=6, rega=3, regb=4, data_imm=0xA5, we_rf=0xFF, mem_we=0, mem_alu=0.
- Load, MEM_LAT=3: instr=0xC012_3456 -> mem_alu=1, we_rf=0xFF, mem_addr=0x123456; in_ready=0 for exactly 3 cycles, then 1.
- JZ: instr=0x9000_0010.
  - With exe_valid, opcode_exe=9, zero=0: jump stays 0.
  - Repeat with zero=1: jump=1 for one cycle.
  - In both cases in_ready=0 from the accept through the resolution (jump) cycle.
- Backpressure: ALU op issued, exe_ready=0 for 4 cycles -> outputs stable and in_ready=0; when exe_ready=1, the next instr is accepted and nothing is lost or duplicated.
- HALT: instr=0xD000_0000 -> halted=1, in_ready=0 for 10 idle cycles; resume pulse -> halted=0 and in_ready=1 the following cycle.
- Reset mid-MEM_WAIT: rst_n=0 at cycle 2 of the wait -> all outputs 0 immediately; after release, in_ready=1.
